// File: rtl/lau_pkg.sv
// -----------------------------------------------------------------------------
// lau_pkg
// Shared types and helpers for the arithmetic unit library.
//   speed_e    : implementation choice for prefix networks (SLOW = ripple,
//                FAST = log-depth Kogge-Stone).
//   num_chunks : ceil(width / chunk), used to size chunked pipelines.
// -----------------------------------------------------------------------------
package lau_pkg;

    typedef enum logic {
        SLOW = 1'b0,
        FAST = 1'b1
    } speed_e;

    function automatic int unsigned num_chunks(input int unsigned width,
                                               input int unsigned chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/sign_apply_pipe_pkg.sv
// -----------------------------------------------------------------------------
// sign_apply_pipe_pkg
// Types local to the sign-apply pipeline.
//   stage_ctl_t : per-stage control register (valid, pending +1 carry, overflow
//                 flag travelling with the word).
// -----------------------------------------------------------------------------
package sign_apply_pipe_pkg;

    typedef struct packed {
        logic vld;
        logic carry;
        logic ovf;
    } stage_ctl_t;

endpackage

// File: rtl/sign_apply_pipe_if.sv
// -----------------------------------------------------------------------------
// sign_apply_pipe_if
// Streaming bus of the sign-apply pipeline: sign-magnitude in, two's
// complement out, valid/ready on both sides.
//   mag_i/sign_i/in_valid_i -> in_ready_o        upstream side
//   z_o/ovf_o/out_valid_o   -> out_ready_i       downstream side
//   slave  : the pipeline
//   master : whoever feeds it and drains it
// -----------------------------------------------------------------------------
interface sign_apply_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] mag_i;
    logic             sign_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] z_o;
    logic             ovf_o;
    logic             out_valid_o;
    logic             out_ready_i;

    modport slave (
        input  mag_i, sign_i, in_valid_i, out_ready_i,
        output in_ready_o, z_o, ovf_o, out_valid_o
    );

    modport master (
        output mag_i, sign_i, in_valid_i, out_ready_i,
        input  in_ready_o, z_o, ovf_o, out_valid_o
    );
endinterface

// File: rtl/prefix_and.sv
// -----------------------------------------------------------------------------
// prefix_and
// Inclusive prefix AND: p[i] = &a[i:0].
//   a : input vector (W bits)
//   p : prefix result (W bits)
// SPEED = FAST builds a log-depth Kogge-Stone network, SLOW a ripple chain.
// -----------------------------------------------------------------------------
module prefix_and #(
    parameter int              W     = 4,
    parameter lau_pkg::speed_e SPEED = lau_pkg::FAST
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] p
);

    if (SPEED == lau_pkg::FAST) begin : g_fast
        localparam int L = (W > 1) ? $clog2(W) : 0;

        // Level l combines each bit with the one 2^(l-1) below it.
        for (genvar l = 0; l <= L; l++) begin : g_lvl
            logic [W-1:0] q;
            if (l == 0) begin : g_base
                assign q = a;
            end else begin : g_step
                localparam int D = 1 << (l - 1);
                for (genvar i = 0; i < W; i++) begin : g_bit
                    if (i >= D) begin : g_and
                        assign q[i] = g_lvl[l-1].q[i] & g_lvl[l-1].q[i-D];
                    end else begin : g_pass
                        assign q[i] = g_lvl[l-1].q[i];
                    end
                end
            end
        end

        assign p = g_lvl[L].q;
    end else begin : g_slow
        logic acc;
        always_comb begin
            acc = 1'b1;
            p   = '0;
            for (int i = 0; i < W; i++) begin
                acc  = acc & a[i];
                p[i] = acc;
            end
        end
    end

endmodule

// File: rtl/sign_apply_pipe_stage.sv
// -----------------------------------------------------------------------------
// sign_apply_stage
// Combinational chunk incrementer: {cout, sum} = chunk + cin.
//   chunk : CHUNK_W-bit chunk of the conditioned word
//   cin   : incoming +1 carry
//   sum   : incremented chunk
//   cout  : carry into the next chunk (cin & all ones in chunk)
// Bit i flips exactly when cin and every lower chunk bit are 1, which is one
// prefix AND over {chunk, cin}.
// -----------------------------------------------------------------------------
module sign_apply_stage #(
    parameter int              CHUNK_W = 4,
    parameter lau_pkg::speed_e SPEED   = lau_pkg::FAST
) (
    input  logic [CHUNK_W-1:0] chunk,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               cout
);

    logic [CHUNK_W:0] pa;

    prefix_and #(
        .W     (CHUNK_W + 1),
        .SPEED (SPEED)
    ) u_pand (
        .a ({chunk, cin}),
        .p (pa)
    );

    assign sum  = chunk ^ pa[CHUNK_W-1:0];
    assign cout = pa[CHUNK_W];

endmodule

// File: rtl/sign_apply_pipe.sv
// -----------------------------------------------------------------------------
// sign_apply_pipe
// Streaming sign-magnitude to two's-complement converter: z = sign ? -mag : mag.
// Negation is ~mag + 1; the +1 ripples one CHUNK-wide chunk per register
// stage so the critical path scales with CHUNK, not WIDTH.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : sign_apply_pipe_if.slave (mag/sign in, z/ovf out, valid/ready)
// Elastic: each stage loads when empty or when its word is being taken; the
// ready chain is combinational back from out_ready_i, so it sustains one word
// per cycle. Outputs come straight from the last stage registers.
// -----------------------------------------------------------------------------
module sign_apply_pipe
    import lau_pkg::*;
    import sign_apply_pipe_pkg::*;
#(
    parameter int     WIDTH = 8,
    parameter int     CHUNK = 4,
    parameter speed_e SPEED = FAST
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    sign_apply_pipe_if.slave bus
);

    localparam int S = int'(num_chunks(WIDTH, CHUNK));

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_param
        $error("sign_apply_pipe: need WIDTH >= 2 and 1 <= CHUNK <= WIDTH");
    end

    // Input conditioning: one's complement plus a pending +1 on the carry.
    logic [WIDTH-1:0] ai;
    logic             ovf0;

    assign ai   = bus.mag_i ^ {WIDTH{bus.sign_i}};
    // Positive results need mag < 2^(W-1); negative ones allow exactly 2^(W-1).
    assign ovf0 = (~bus.sign_i & bus.mag_i[WIDTH-1])
                | ( bus.sign_i & bus.mag_i[WIDTH-1] & (|bus.mag_i[WIDTH-2:0]));

    // go[k] = stage k may load this cycle; go[S] is the downstream ready.
    logic [S-1:0] vld;
    logic [S:0]   go;

    always_comb begin
        go    = '0;
        go[S] = bus.out_ready_i;
        for (int k = S - 1; k >= 0; k--) begin
            go[k] = ~vld[k] | go[k+1];
        end
    end

    assign bus.in_ready_o = go[0];

    for (genvar k = 0; k < S; k++) begin : g_stg
        localparam int LO = k * CHUNK;
        localparam int CW = (WIDTH - LO < CHUNK) ? (WIDTH - LO) : CHUNK;

        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] data_q;
        logic [CW-1:0]    sum;
        logic             cin;
        logic             cout;
        logic             vin;
        logic             oin;
        stage_ctl_t       ctl_q;

        if (k == 0) begin : g_src_in
            assign din = ai;
            assign cin = bus.sign_i;
            assign vin = bus.in_valid_i;
            assign oin = ovf0;
        end else begin : g_src_stg
            assign din = g_stg[k-1].data_q;
            assign cin = g_stg[k-1].ctl_q.carry;
            assign vin = g_stg[k-1].ctl_q.vld;
            assign oin = g_stg[k-1].ctl_q.ovf;
        end

        sign_apply_stage #(
            .CHUNK_W (CW),
            .SPEED   (SPEED)
        ) u_stage (
            .chunk (din[LO +: CW]),
            .cin   (cin),
            .sum   (sum),
            .cout  (cout)
        );

        // Only this stage's chunk changes; the rest rides along.
        always_comb begin
            nxt           = din;
            nxt[LO +: CW] = sum;
        end

        // Data only moves with a valid word so an idle, possibly-X input bus
        // never reaches the registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ctl_q  <= '0;
                data_q <= '0;
            end else if (go[k]) begin
                ctl_q.vld <= vin;
                if (vin) begin
                    data_q      <= nxt;
                    ctl_q.carry <= cout;
                    ctl_q.ovf   <= oin;
                end
            end
        end

        assign vld[k] = ctl_q.vld;
    end

    // The carry out of the top chunk is dropped (modular result).
    logic unused_carry;
    assign unused_carry = g_stg[S-1].ctl_q.carry;

    assign bus.z_o         = g_stg[S-1].data_q;
    assign bus.ovf_o       = g_stg[S-1].ctl_q.ovf;
    assign bus.out_valid_o = g_stg[S-1].ctl_q.vld;

endmodule
